// File: rtl/top_demux_gather.sv
// Serial-to-row gather: packs BW-bit words into successive lanes of a BW*N row.
// Latency: the row is presented one cycle after its final word (or a flush) is accepted.
// Backpressure: in_ready drops while a row is held; the row is held until out_ready.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_data/in_valid     serial word stream; in_ready = block is filling
//   in_last              final word of a (possibly short) row
//   flush                close a partial row without data (ignored when empty or holding)
//   out_data/out_valid   assembled row, lane 0 in the low BW bits; out_ready = consumer takes it
//   out_count            number of lanes written in the presented row (1..N)
module top_demux_gather #(
    parameter int BW  = 8,
    parameter int N   = 8,
    parameter int SEL = $clog2(N),
    parameter int CW  = $clog2(N + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BW-1:0]     in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic              flush,
    output logic [BW*N-1:0]   out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW-1:0]     out_count
);

    typedef enum logic {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SEL-1:0]         r_wr_ptr;
    logic [N-1:0][BW-1:0]   r_lanes;
    logic [CW-1:0]          r_count;
    logic [CW-1:0]          w_count_nxt;
    logic                   w_accept;
    logic                   w_take;
    logic                   w_ptr_last;

    assign in_ready   = (r_state == S_FILL);
    assign out_valid  = (r_state == S_HOLD);
    assign w_accept   = in_valid & in_ready;
    assign w_take     = out_valid & out_ready;
    assign w_ptr_last = (r_wr_ptr == SEL'(N - 1));

    assign out_data  = r_lanes;
    assign out_count = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FILL;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            S_FILL: begin
                if (w_accept && (w_ptr_last || in_last || flush)) begin
                    // The word being accepted this cycle is part of the row.
                    w_state_nxt = S_HOLD;
                    w_count_nxt = CW'(r_wr_ptr) + CW'(1);
                end else if (!w_accept && flush && (r_wr_ptr != '0)) begin
                    // Flush without data closes what is already stored; an empty
                    // row is never emitted.
                    w_state_nxt = S_HOLD;
                    w_count_nxt = CW'(r_wr_ptr);
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = S_FILL;
                    w_count_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_FILL;
                w_count_nxt = '0;
            end
        endcase
    end

    // Lanes are cleared when a row leaves so short rows come out zero-padded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_lanes  <= '0;
        end else if (w_take) begin
            r_wr_ptr <= '0;
            r_lanes  <= '0;
        end else if (w_accept) begin
            r_lanes[r_wr_ptr] <= in_data;
            // Wraps only on the terminal word, which always moves to HOLD, and
            // the pointer is reloaded when the row is taken.
            r_wr_ptr <= r_wr_ptr + SEL'(1);
        end
    end

endmodule

// File: tb/tb_top_demux_gather.sv
module tb_top_demux_gather;

    localparam int BW = 8;
    localparam int N  = 8;
    localparam int CW = 4;

    logic              clk;
    logic              rst;
    logic [BW-1:0]     in_data;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic              flush;
    logic [BW*N-1:0]   out_data;
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     out_count;

    top_demux_gather #(.BW(BW), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [BW*N-1:0] d;
        logic [CW-1:0]   c;
    } row_t;

    row_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    logic prod_done   = 1'b0;

    // Presents one word (called at a negedge) and returns at the negedge right
    // after the posedge that accepted it.
    task automatic send_word(input logic [BW-1:0] d, input logic last, input logic fl);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        flush    = fl;
        for (int c = 0; c <= 300; c++) begin
            if (c == 300) begin
                vectors++;
                miscompares++;
                $display("FAIL send_timeout word=%h in_ready=%b required 1", d, in_ready);
                break;
            end
            if (in_ready) begin
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        vectors++;
        if (out_data !== '0) begin miscompares++; $display("FAIL rst_out_data got %h want 0", out_data); end
        vectors++;
        if (out_count !== '0) begin miscompares++; $display("FAIL rst_out_count got %0d want 0", out_count); end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_full_row;
        row_t e;
        out_ready = 1'b1;
        sb.push_back({64'h8877665544332211, 4'd8});
        for (int i = 0; i < N; i++) send_word(8'((i + 1) * 17), 1'b0, 1'b0);
        e = sb.pop_front();
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL full_valid got %b want 1", out_valid); end
        vectors++;
        if (out_data !== e.d) begin miscompares++; $display("FAIL full_data got %h want %h", out_data, e.d); end
        vectors++;
        if (out_count !== e.c) begin miscompares++; $display("FAIL full_count got %0d want %0d", out_count, e.c); end
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL full_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_short_last;
        row_t e;
        out_ready = 1'b1;
        sb.push_back({64'h0000000000A3A2A1, 4'd3});
        send_word(8'hA1, 1'b0, 1'b0);
        send_word(8'hA2, 1'b0, 1'b0);
        send_word(8'hA3, 1'b1, 1'b0);
        e = sb.pop_front();
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL last_valid got %b want 1", out_valid); end
        vectors++;
        if (out_data !== e.d) begin miscompares++; $display("FAIL last_data got %h want %h", out_data, e.d); end
        vectors++;
        if (out_count !== e.c) begin miscompares++; $display("FAIL last_count got %0d want %0d", out_count, e.c); end
        @(negedge clk);
    endtask

    task automatic test_flush;
        row_t e;
        out_ready = 1'b1;
        sb.push_back({64'h0000000000000605, 4'd2});
        send_word(8'h05, 1'b0, 1'b0);
        send_word(8'h06, 1'b0, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        e = sb.pop_front();
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL flush_valid got %b want 1", out_valid); end
        vectors++;
        if (out_data !== e.d) begin miscompares++; $display("FAIL flush_data got %h want %h", out_data, e.d); end
        vectors++;
        if (out_count !== e.c) begin miscompares++; $display("FAIL flush_count got %0d want %0d", out_count, e.c); end
        @(negedge clk);
        // Flush on an empty buffer must not produce a row.
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL flush_empty got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
            end
            @(negedge clk);
        end
        sb.push_back({64'h000000000000005A, 4'd1});
        send_word(8'h5A, 1'b1, 1'b0);
        e = sb.pop_front();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== e.d || out_count !== e.c) begin
            miscompares++;
            $display("FAIL flush_empty_next got v=%b d=%h c=%0d want 1 %h %0d", out_valid, out_data, out_count, e.d, e.c);
        end
        @(negedge clk);
    endtask

    task automatic test_hold;
        row_t e;
        out_ready = 1'b0;
        sb.push_back({64'h2827262524232221, 4'd8});
        for (int i = 0; i < N; i++) send_word(8'(8'h21 + i), 1'b0, 1'b0);
        e = sb.pop_front();
        in_data  = 8'hFF;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== e.d) begin
                miscompares++;
                $display("FAIL hold_stable cyc=%0d got v=%b rdy=%b d=%h want 1 0 %h", k, out_valid, in_ready, out_data, e.d);
            end
            @(negedge clk);
        end
        vectors++;
        if (out_count !== e.c) begin miscompares++; $display("FAIL hold_count got %0d want %0d", out_count, e.c); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        sb.push_back({64'h0000000000003231, 4'd2});
        send_word(8'h31, 1'b0, 1'b0);
        send_word(8'h32, 1'b1, 1'b0);
        e = sb.pop_front();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== e.d || out_count !== e.c) begin
            miscompares++;
            $display("FAIL hold_next_row got v=%b d=%h c=%0d want 1 %h %0d", out_valid, out_data, out_count, e.d, e.c);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        row_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_word(8'(8'h41 + i), 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0 || out_count !== '0) begin
            miscompares++;
            $display("FAIL async_rst got v=%b rdy=%b d=%h c=%0d want 0 1 0 0", out_valid, in_ready, out_data, out_count);
        end
        #1;
        rst = 1'b0;
        @(negedge clk);
        sb.push_back({64'h5857565554535251, 4'd8});
        for (int i = 0; i < N; i++) send_word(8'(8'h51 + i), 1'b0, 1'b0);
        e = sb.pop_front();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== e.d || out_count !== e.c) begin
            miscompares++;
            $display("FAIL async_rst_row got v=%b d=%h c=%0d want 1 %h %0d", out_valid, out_data, out_count, e.d, e.c);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        prod_done = 1'b0;
        fork
            begin
                for (int r = 0; r < 100; r++) begin
                    row_t        e;
                    int          len;
                    int          mode;
                    logic [7:0]  w;
                    len  = $urandom_range(1, N);
                    mode = $urandom_range(0, 2);
                    e.d  = '0;
                    e.c  = CW'(len);
                    for (int i = 0; i < len; i++) e.d[i*BW +: BW] = 8'(r * 7 + i * 13 + 1);
                    sb.push_back(e);
                    for (int i = 0; i < len; i++) begin
                        if ($urandom_range(0, 3) == 0) begin
                            in_data = 8'($urandom);
                            @(negedge clk);
                        end
                        w = e.d[i*BW +: BW];
                        send_word(w, (i == len - 1) && (mode == 0), (i == len - 1) && (mode == 1));
                    end
                    if (mode == 2) begin
                        flush = 1'b1;
                        @(negedge clk);
                        flush = 1'b0;
                    end
                end
                prod_done = 1'b1;
            end
            begin
                row_t e;
                int   cyc;
                cyc = 0;
                while ((!prod_done || sb.size() > 0) && cyc < 20000) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    if (out_valid && out_ready) begin
                        vectors++;
                        if (sb.size() == 0) begin
                            miscompares++;
                            $display("FAIL rand_extra_row got d=%h c=%0d want none", out_data, out_count);
                        end else begin
                            e = sb.pop_front();
                            if (out_data !== e.d || out_count !== e.c) begin
                                miscompares++;
                                $display("FAIL rand_row got d=%h c=%0d want %h %0d", out_data, out_count, e.d, e.c);
                            end
                        end
                    end
                    @(negedge clk);
                    cyc++;
                end
                out_ready = 1'b0;
            end
        join
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL rand_drain got %0d rows pending want 0", sb.size());
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_full_row();
        test_short_last();
        test_flush();
        test_hold();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
